// File: rtl/glitch_pkg.sv
// Shared definitions for the clock-glitch sequencer and the glitcher integration top.
package glitch_pkg;

  localparam int DLY_W_DEFAULT = 16;
  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_FIRE,
    ST_SPACE
  } glitch_state_t;

  function automatic logic is_busy_state(input glitch_state_t s);
    return (s == ST_DELAY) || (s == ST_FIRE) || (s == ST_SPACE);
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that stops at zero; shared by the delay and spacing phases.
module load_down_counter
  import glitch_pkg::*;
#(
  parameter int WIDTH = DLY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/glitch_scheduler.sv
// Arms on request, waits for a trigger rising edge, then emits N glitch pulses
// after a delay of D cycles at a spacing of max(S,1)+1 cycles.
module glitch_scheduler
  import glitch_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             abort,
  input  logic             ext_trig,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [DLY_W-1:0] cfg_spacing,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             glitch_trig,
  output logic             armed,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] fired
);

  glitch_state_t state, next_state;

  logic             prev_trig;
  logic             trig_rise;
  logic [DLY_W-1:0] d_lat;
  logic [DLY_W-1:0] s_lat;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] fired_inc;
  logic             cfg_latch;
  logic             fire_now;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_zero;
  logic [DLY_W-1:0] cnt_load_val;

  assign trig_rise = ext_trig && !prev_trig;
  assign fired_inc = fired + 1'b1;

  load_down_counter #(
    .WIDTH(DLY_W)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .en      (cnt_en),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // abort overrides every other request, including arm and a trigger edge
  always_comb begin
    next_state   = state;
    cfg_latch    = 1'b0;
    fire_now     = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = '0;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm && (cfg_count != '0)) begin
            cfg_latch  = 1'b1;
            next_state = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (trig_rise) begin
            if (d_lat != '0) begin
              next_state   = ST_DELAY;
              cnt_load     = 1'b1;
              cnt_load_val = d_lat - 1'b1;
            end else begin
              next_state = ST_FIRE;
            end
          end
        end
        ST_DELAY, ST_SPACE: begin
          if (cnt_zero) begin
            next_state = ST_FIRE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_FIRE: begin
          fire_now = 1'b1;
          if (fired_inc == n_lat) begin
            next_state = ST_IDLE;
          end else begin
            next_state   = ST_SPACE;
            cnt_load     = 1'b1;
            cnt_load_val = (s_lat == '0) ? '0 : s_lat - 1'b1;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // busy stays up through the last pulse cycle so it drops together with done rising
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_trig   <= 1'b0;
      d_lat       <= '0;
      s_lat       <= '0;
      n_lat       <= '0;
      fired       <= '0;
      glitch_trig <= 1'b0;
      armed       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      prev_trig <= ext_trig;
      if (cfg_latch) begin
        d_lat <= cfg_delay;
        s_lat <= cfg_spacing;
        n_lat <= cfg_count;
        fired <= '0;
      end else if (fire_now && (fired != n_lat)) begin
        fired <= fired_inc;
      end
      glitch_trig <= fire_now;
      armed       <= (next_state == ST_ARMED);
      busy        <= is_busy_state(next_state) || fire_now;
      done        <= glitch_trig && (fired == n_lat) && !abort;
    end
  end

endmodule

// File: tb/tb_glitch_scheduler.sv
// Self-checking bench: directed scenarios with literal timing plus randomized
// traffic compared every cycle against a pulse-schedule model.
module tb_glitch_scheduler;
  import glitch_pkg::*;

  localparam int DLY_W = DLY_W_DEFAULT;
  localparam int CNT_W = CNT_W_DEFAULT;
  localparam longint NEVER = 64'd1 << 60;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             arm;
  logic             abort;
  logic             ext_trig;
  logic [DLY_W-1:0] cfg_delay;
  logic [DLY_W-1:0] cfg_spacing;
  logic [CNT_W-1:0] cfg_count;
  logic             glitch_trig;
  logic             armed;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] fired;

  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;
  bit     chk_en = 1'b0;
  longint pulse_q[$];
  longint done_q[$];
  longint t_edge;

  // model: a run is a fixed list of pulse cycles computed at the trigger edge
  bit     m_armed, m_run, m_prev;
  longint m_t0, m_last, m_abort, m_done_at;
  int     m_d, m_s, m_n;
  bit     e_glitch, e_armed, e_busy, e_done;
  int     e_fired;

  always #5 clk = ~clk;

  glitch_scheduler #(
    .DLY_W(DLY_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .abort      (abort),
    .ext_trig   (ext_trig),
    .cfg_delay  (cfg_delay),
    .cfg_spacing(cfg_spacing),
    .cfg_count  (cfg_count),
    .glitch_trig(glitch_trig),
    .armed      (armed),
    .busy       (busy),
    .done       (done),
    .fired      (fired)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0d, required %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
    end
  endtask

  task automatic apply_stimulus(input logic a, input logic ab, input logic tr);
    @(negedge clk);
    arm      = a;
    abort    = ab;
    ext_trig = tr;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, ext_trig);
  endtask

  task automatic set_cfg(input int d, input int s, input int n);
    cfg_delay   = DLY_W'(d);
    cfg_spacing = DLY_W'(s);
    cfg_count   = CNT_W'(n);
  endtask

  function automatic longint q_at(input longint q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_armed = 0; m_run = 0; m_prev = 0;
      m_abort = NEVER; m_done_at = NEVER;
      e_glitch = 0; e_armed = 0; e_busy = 0; e_done = 0; e_fired = 0;
    end else begin
      longint c;
      bit     rise;
      bit     busy_prev;
      cyc++;
      c = cyc;
      rise   = ext_trig && !m_prev;
      m_prev = ext_trig;
      busy_prev = m_run && (m_abort > c - 1) && (m_t0 <= c - 1) && (c - 1 < m_last);
      if (abort) begin
        m_armed = 0;
        if (m_run && m_abort == NEVER) m_abort = c;
        if (m_done_at >= c) m_done_at = NEVER;
      end else if (!m_armed && !busy_prev) begin
        if (arm && cfg_count != 0) begin
          m_d = int'(cfg_delay);
          m_s = (cfg_spacing == 0) ? 1 : int'(cfg_spacing);
          m_n = int'(cfg_count);
          m_armed = 1;
          m_run   = 0;
        end
      end else if (m_armed && rise) begin
        m_armed   = 0;
        m_run     = 1;
        m_t0      = c;
        m_abort   = NEVER;
        m_last    = c + 1 + m_d + longint'(m_n - 1) * (m_s + 1);
        m_done_at = m_last + 1;
      end
      e_glitch = 0;
      e_fired  = 0;
      e_armed  = m_armed;
      e_busy   = m_run && (m_t0 <= c) && (c <= m_last) && (c < m_abort);
      e_done   = (c == m_done_at);
      if (m_run) begin
        for (int k = 0; k < m_n; k++) begin
          longint p;
          p = m_t0 + 1 + m_d + longint'(k) * (m_s + 1);
          if (p < m_abort) begin
            if (p == c) e_glitch = 1;
            if (p <= c) e_fired++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      check_output("glitch_trig", 32'(glitch_trig), 32'(e_glitch));
      check_output("armed", 32'(armed), 32'(e_armed));
      check_output("busy", 32'(busy), 32'(e_busy));
      check_output("done", 32'(done), 32'(e_done));
      check_output("fired", 32'(fired), 32'(e_fired));
      if (glitch_trig) pulse_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
    end
  end

  initial begin
    arm = 0; abort = 0; ext_trig = 0;
    set_cfg(0, 0, 0);
    #1 rst = 1'b0;
    #11;
    check_output("reset_glitch_trig", 32'(glitch_trig), 0);
    check_output("reset_armed", 32'(armed), 0);
    check_output("reset_busy", 32'(busy), 0);
    check_output("reset_done", 32'(done), 0);
    check_output("reset_fired", 32'(fired), 0);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    idle_cycles(2);

    // D=3 N=1: single pulse at T+4, done at T+5; config changes after arm ignored
    pulse_q.delete(); done_q.delete();
    set_cfg(3, 0, 1);
    apply_stimulus(1, 0, 0);
    apply_stimulus(0, 0, 0);
    set_cfg(9, 9, 9);
    apply_stimulus(0, 0, 1);
    t_edge = cyc + 1;
    idle_cycles(10);
    check_output("t1_pulse_count", 32'(pulse_q.size()), 1);
    check_output("t1_pulse_time", 32'(q_at(pulse_q, 0) - t_edge), 4);
    check_output("t1_done_time", 32'(q_at(done_q, 0) - t_edge), 5);
    check_output("t1_fired", 32'(fired), 1);

    // D=0 N=3 S=0: pulses at T+1, T+3, T+5, done at T+6
    pulse_q.delete(); done_q.delete();
    set_cfg(0, 0, 3);
    apply_stimulus(1, 0, 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 0, 1);
    t_edge = cyc + 1;
    idle_cycles(10);
    check_output("t2_pulse_count", 32'(pulse_q.size()), 3);
    check_output("t2_pulse0", 32'(q_at(pulse_q, 0) - t_edge), 1);
    check_output("t2_pulse1", 32'(q_at(pulse_q, 1) - t_edge), 3);
    check_output("t2_pulse2", 32'(q_at(pulse_q, 2) - t_edge), 5);
    check_output("t2_done_time", 32'(q_at(done_q, 0) - t_edge), 6);
    check_output("t2_fired", 32'(fired), 3);

    // D=2 N=2 S=4: pulses at T+3, T+8; a second edge during SPACE adds nothing
    pulse_q.delete(); done_q.delete();
    set_cfg(2, 4, 2);
    apply_stimulus(1, 0, 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 0, 1);
    t_edge = cyc + 1;
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 0, 1);
    idle_cycles(12);
    check_output("t3_pulse_count", 32'(pulse_q.size()), 2);
    check_output("t3_pulse0", 32'(q_at(pulse_q, 0) - t_edge), 3);
    check_output("t3_pulse1", 32'(q_at(pulse_q, 1) - t_edge), 8);

    // trigger already high at arm time: no run until a fresh rising edge
    pulse_q.delete(); done_q.delete();
    set_cfg(1, 0, 1);
    apply_stimulus(0, 0, 1);
    apply_stimulus(1, 0, 1);
    idle_cycles(5);
    check_output("t4_still_armed", 32'(armed), 1);
    check_output("t4_no_pulse", 32'(pulse_q.size()), 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 0, 1);
    t_edge = cyc + 1;
    idle_cycles(6);
    check_output("t4_pulse_time", 32'(q_at(pulse_q, 0) - t_edge), 2);

    // abort in SPACE after the first of four pulses
    pulse_q.delete(); done_q.delete();
    set_cfg(0, 3, 4);
    apply_stimulus(1, 0, 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 0, 1);
    t_edge = cyc + 1;
    apply_stimulus(0, 0, 1);
    apply_stimulus(0, 0, 1);
    apply_stimulus(0, 1, 1);
    idle_cycles(12);
    check_output("t5_pulse_count", 32'(pulse_q.size()), 1);
    check_output("t5_done_count", 32'(done_q.size()), 0);
    check_output("t5_fired", 32'(fired), 1);
    check_output("t5_busy", 32'(busy), 0);

    // arm with N=0 is ignored
    apply_stimulus(0, 0, 0);
    set_cfg(2, 0, 0);
    apply_stimulus(1, 0, 0);
    idle_cycles(2);
    check_output("t6_n0_armed", 32'(armed), 0);

    // arm while busy is ignored
    pulse_q.delete(); done_q.delete();
    set_cfg(5, 0, 1);
    apply_stimulus(1, 0, 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 0, 1);
    t_edge = cyc + 1;
    apply_stimulus(0, 0, 1);
    set_cfg(0, 0, 3);
    apply_stimulus(1, 0, 1);
    idle_cycles(10);
    check_output("t6_busy_arm_pulses", 32'(pulse_q.size()), 1);
    check_output("t6_busy_arm_time", 32'(q_at(pulse_q, 0) - t_edge), 6);

    // asynchronous reset mid-DELAY clears outputs immediately
    set_cfg(10, 0, 1);
    apply_stimulus(1, 0, 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 0, 1);
    idle_cycles(3);
    check_output("t7_busy_before_rst", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check_output("t7_rst_glitch_trig", 32'(glitch_trig), 0);
    check_output("t7_rst_armed", 32'(armed), 0);
    check_output("t7_rst_busy", 32'(busy), 0);
    check_output("t7_rst_done", 32'(done), 0);
    check_output("t7_rst_fired", 32'(fired), 0);
    ext_trig = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(2);

    // randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_cfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
      apply_stimulus($urandom_range(0, 7) == 0, $urandom_range(0, 79) == 0,
                     ($urandom_range(0, 3) == 0) ? !ext_trig : ext_trig);
    end
    idle_cycles(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/glitch_scheduler.md
# glitch_scheduler

Sequencer for the single-shot clock glitcher (`glitch_clk_single`). After being armed, waits for a rising edge on an external trigger, counts a programmable delay, then issues a programmable number of one-cycle `trig` pulses to the glitcher at a programmable spacing. Sits between the host configuration registers and the glitcher's `trig` input, in the fast `clk` domain.

## Interface
- `DLY_W`, 16: width of delay and spacing fields, in clk cycles.
- `CNT_W`, 8: width of glitch-count field.
- `clk`  in  1  fast system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `arm`  in  1  one-cycle request to latch config and wait for trigger.
- `abort`  in  1  one-cycle request to cancel any run.
- `ext_trig`  in  1  target trigger, already synchronous to `clk`; rising edge starts a run.
- `cfg_delay`  in  DLY_W  cycles from trigger edge to first pulse (D).
- `cfg_spacing`  in  DLY_W  pulse spacing (S).
- `cfg_count`  in  CNT_W  pulses per run (N).
- `glitch_trig`  out  1  registered one-cycle pulse to glitcher `trig`.
- `armed`  out  1  high while waiting for trigger.
- `busy`  out  1  high in DELAY, FIRE, SPACE.
- `done`  out  1  one-cycle pulse after last pulse of a completed run.
- `fired`  out  CNT_W  pulses issued in current/last run.

## Operation
- States: IDLE, ARMED, DELAY, FIRE, SPACE.
- IDLE: `arm`=1 and `cfg_count`!=0 -> latch D, S, N into internal registers, clear `fired`, go ARMED. `arm` with N=0 ignored.
- ARMED: rising edge (`ext_trig`=1, previous sample 0) -> DELAY if D>0, else FIRE. Level already high at arm time does not fire; edge register updates in every state.
- DELAY: down-counter loaded D-1 on entry; at 0 -> FIRE.
- FIRE: one cycle; drives `glitch_trig` next edge, `fired`+1. If `fired` reaches N -> IDLE with `done`; else SPACE.
- SPACE: counter loaded max(S,1)-1; at 0 -> FIRE. Pulses therefore always separated by ≥1 low cycle.
- `ext_trig` edges outside ARMED ignored (no retrigger). `arm` outside IDLE ignored. Config input changes after latch have no effect on the run.
- `abort` in any state -> IDLE next cycle; `glitch_trig` low, `done` not asserted, `fired` holds. `abort` beats `arm` and trigger edge in same cycle.
- `fired` saturates at N; counters are modulo-free down-counters, no wrap.

## Timing
- Reset values: state IDLE; `glitch_trig`, `armed`, `busy`, `done` = 0; `fired` = 0; edge register 0.
- All outputs registered.
- Edge sampled at clock edge T -> first `glitch_trig` high in cycle T+1+D.
- Rising edges of consecutive `glitch_trig` pulses separated by max(S,1)+1 cycles.
- `done` high in the cycle immediately after the last `glitch_trig` cycle; `busy` low from that cycle.
- `armed` high from cycle after accepted `arm` until cycle after trigger edge.
- Reset mid-run: outputs drop asynchronously; no partial pulse may be stretched.

## Structure
- Package `glitch_pkg`: state enum, default `DLY_W`/`CNT_W` constants, shared with glitcher top.
- One sub-module `load_down_counter` (load, enable, zero flag, parameter width), instantiated once, reused for DELAY and SPACE.
- Glitcher itself not instantiated here; integration top wires `glitch_trig` to its `trig`.

## Test plan
- Reset, arm D=3 N=1 S=0, ext_trig edge at T -> single `glitch_trig` at T+4, `done` at T+5, `fired`=1.
- D=0 N=3 S=0 -> pulses at T+1, T+3, T+5 (S=0 clamped to 1), `done` at T+6.
- D=2 N=2 S=4 -> pulses at T+3, T+8; second ext_trig edge during SPACE produces no extra pulse.
- ext_trig held high while arming, no edge -> stays ARMED, no pulse; fall then rise -> run starts.
- `abort` during SPACE after first of N=4 pulses -> IDLE next cycle, no further pulses, no `done`, `fired`=1.
- `arm` with N=0, and `arm` while busy -> ignored; async `rst` low mid-DELAY -> all outputs 0 immediately.
